frame_sequencer: RTL
====================

Name: frame_sequencer

Overview:
Top-level pipeline sequencer in the i_sysclk (125 MHz) domain. Owns the bring-up sequence: camera configuration start, cfg_done wait with timeout and retry, alignment to the first start-of-frame, and pipeline flush. In steady state it applies Gaussian-filter enable changes only at frame boundaries, each followed by a timed flush of the filter and memory-interface pipeline. Drives cam_top's cfg_init, and the enable/flush inputs of kp_gaussian_top and mem_interface.

Parameters:
CFG_TIMEOUT, 12500000, cycles allowed in CFG_WAIT for a cfg_done rising edge (100 ms)
MAX_RETRIES, 3, configuration restarts allowed before FAULT
FLUSH_CYCLES, 16, exact width of o_pipe_flush in cycles (>=1)
SW_STABLE, 1024, cycles the synchronised switch must be stable before it is accepted
WDT_CYCLES, 25000000, SOF watchdog period in RUN (feature only)

Ports:
i_sysclk  in  1  system clock, 125 MHz
db_rstn  in  1  asynchronous, active-low reset
i_sof  in  1  start-of-frame pulse, one cycle, synchronous to i_sysclk
i_cfg_done  in  1  camera configuration complete, level
i_sw_gaussian  in  1  raw board switch, asynchronous
o_cfg_start  out  1  one-cycle configuration start pulse
o_gaussian_enable  out  1  filter enable, changes only at flush entry
o_pipe_flush  out  1  pipeline flush strobe
o_running  out  1  high in RUN
o_cfg_err  out  1  sticky, set on entry to FAULT
o_status_leds  out  4  [0] configured, [1] running, [2] gaussian_enable, [3] fault

Behaviour:
- Clock and reset: single clock i_sysclk. Reset is db_rstn, asynchronous assert, active-low. During reset every output is 0, state is IDLE, and all counters are 0. All outputs are registered.
- Switch filter: 2-FF synchroniser feeds sw_sync. A stability counter clears whenever sw_sync != sw_filt. When the counter reaches SW_STABLE-1, sw_filt <= sw_sync. sw_filt resets to 0.
- cfg_done edge: cfg_rise = i_cfg_done & ~cfg_done_q. Only a rising edge is accepted, so a stale high level never completes a configuration.
- State machine: IDLE, CFG_START, CFG_WAIT, SYNC_WAIT, FLUSH, RUN, FAULT.
  - IDLE: go to CFG_START after 1 cycle. o_cfg_start is high during the 2nd clock after reset release.
  - CFG_START: o_cfg_start=1 for exactly 1 cycle. Clear the timeout counter. Go to CFG_WAIT.
  - CFG_WAIT, on cfg_rise: set led[0]. Go to SYNC_WAIT.
  - CFG_WAIT, on timeout reaching CFG_TIMEOUT-1 without cfg_rise: if retry_cnt < MAX_RETRIES, retry_cnt++ and go to CFG_START; otherwise go to FAULT.
  - CFG_WAIT, cfg_rise and timeout in the same cycle: cfg_rise wins.
  - SYNC_WAIT: on i_sof, go to FLUSH.
  - FLUSH entry: o_gaussian_enable <= sw_filt, and o_pipe_flush rises in the same cycle. o_pipe_flush stays high exactly FLUSH_CYCLES cycles, then go to RUN.
  - RUN: o_running=1. change_pending = (sw_filt != o_gaussian_enable). An i_sof with change_pending true in the same cycle goes to FLUSH. An i_sof without a pending change is ignored.
  - FAULT: o_cfg_err=1 and led[3]=1. Terminal until reset.
- i_sof is ignored in every state except SYNC_WAIT and RUN. This includes FLUSH, so a sof during a flush does not extend it.
- Switch toggles that occur while in FLUSH are evaluated at the next sof in RUN.
- Switch toggles shorter than SW_STABLE cycles never reach o_gaussian_enable.
- Reset mid-operation: immediate return to IDLE with outputs cleared. A reset during FLUSH drops o_pipe_flush asynchronously.
- retry_cnt saturates at MAX_RETRIES and is cleared only by reset.

Optional Feature:
Macro: FRAME_SEQ_SOF_WDT_EN.
- Defined: a counter runs in RUN and clears on every i_sof.
- On reaching WDT_CYCLES-1 with no sof, the block clears led[0] and o_running and goes to CFG_START. retry_cnt is cleared first, so a full reconfiguration follows.
- Not defined: the counter and its logic are absent, and RUN is left only through FLUSH or reset.

Test Plan:
- Reset release, sw=0, cfg_done rising at cycle 50, sof at cycle 200 -> o_cfg_start is high only in cycle 2. o_pipe_flush is high for cycles 201–216 (FLUSH_CYCLES=16). o_running=1 from cycle 217. o_gaussian_enable=0.
- CFG_TIMEOUT=100 and cfg_done held at 0 -> o_cfg_start pulses 4 times, 101 cycles apart. Then o_cfg_err=1 and led=4'b1000. Later sof and cfg_done are ignored.
- i_cfg_done held high through reset -> no progression past CFG_WAIT until it falls and rises again. A timeout retry occurs if the edge is absent.
- In RUN, sw set to 1 (SW_STABLE=8) -> no change until the next sof. At that sof o_gaussian_enable=1 and o_pipe_flush rise together, flush lasts 16 cycles, then RUN resumes.
- A 5-cycle sw glitch (SW_STABLE=8) followed by sof -> no flush, and o_gaussian_enable is unchanged.
- FRAME_SEQ_SOF_WDT_EN with WDT_CYCLES=500 and no sof in RUN -> at cycle 500, o_running drops and o_cfg_start pulses. db_rstn asserted mid-FLUSH -> all outputs read 0 in the same cycle.

Source files
------------

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// frame_sequencer : camera bring-up, SOF alignment and timed pipeline flush.
// Optional SOF watchdog in RUN: define FRAME_SEQ_SOF_WDT_EN.
// Revision: 1.0
// ============================================================================
module frame_sequencer #(
  parameter int CFG_TIMEOUT  = 12500000,
  parameter int MAX_RETRIES  = 3,
  parameter int FLUSH_CYCLES = 16,
  parameter int SW_STABLE    = 1024
`ifdef FRAME_SEQ_SOF_WDT_EN
  , parameter int WDT_CYCLES = 25000000
`endif
) (
  input  logic       i_sysclk,
  input  logic       db_rstn,
  input  logic       i_sof,
  input  logic       i_cfg_done,
  input  logic       i_sw_gaussian,
  output logic       o_cfg_start,
  output logic       o_gaussian_enable,
  output logic       o_pipe_flush,
  output logic       o_running,
  output logic       o_cfg_err,
  output logic [3:0] o_status_leds
);

  localparam int TO_W = (CFG_TIMEOUT  > 1) ? $clog2(CFG_TIMEOUT)  : 1;
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SB_W = (SW_STABLE    > 1) ? $clog2(SW_STABLE)    : 1;
  localparam int RT_W = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(CFG_TIMEOUT - 1);
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [SB_W-1:0] SB_MAX = SB_W'(SW_STABLE - 1);
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_START = 3'd1,
    CFG_WAIT  = 3'd2,
    SYNC_WAIT = 3'd3,
    FLUSH     = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  state_t          state_q,     state_d;
  logic            sw_meta_q,   sw_meta_d;
  logic            sw_sync_q,   sw_sync_d;
  logic            sw_filt_q,   sw_filt_d;
  logic [SB_W-1:0] stab_q,      stab_d;
  logic            cfg_done_q,  cfg_done_d;
  logic [TO_W-1:0] timeout_q,   timeout_d;
  logic [RT_W-1:0] retry_q,     retry_d;
  logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            cfg_start_q, cfg_start_d;
  logic            gauss_q,     gauss_d;
  logic            flush_q,     flush_d;
  logic            running_q,   running_d;
  logic            config_q,    config_d;
  logic            cfg_err_q,   cfg_err_d;
`ifdef FRAME_SEQ_SOF_WDT_EN
  localparam int WD_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDT_CYCLES - 1);
  logic [WD_W-1:0] wdt_q, wdt_d;
`endif

  logic cfg_rise;
  logic change_pending;

  assign cfg_rise       = i_cfg_done & ~cfg_done_q;
  assign change_pending = (sw_filt_q != gauss_q);

  always_comb begin
    sw_meta_d   = i_sw_gaussian;
    sw_sync_d   = sw_meta_q;
    cfg_done_d  = i_cfg_done;
    sw_filt_d   = sw_filt_q;
    stab_d      = '0;
    state_d     = state_q;
    timeout_d   = timeout_q;
    retry_d     = retry_q;
    flush_cnt_d = flush_cnt_q;
    cfg_start_d = 1'b0;
    gauss_d     = gauss_q;
    flush_d     = flush_q;
    running_d   = running_q;
    config_d    = config_q;
    cfg_err_d   = cfg_err_q;
`ifdef FRAME_SEQ_SOF_WDT_EN
    wdt_d       = '0;
`endif

    // Counter only runs while the synchronised switch disagrees with the accepted value
    if (sw_sync_q != sw_filt_q) begin
      if (stab_q == SB_MAX) begin
        sw_filt_d = sw_sync_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        state_d     = CFG_START;
        cfg_start_d = 1'b1;
      end
      CFG_START: begin
        state_d   = CFG_WAIT;
        timeout_d = '0;
      end
      CFG_WAIT: begin
        if (cfg_rise) begin
          config_d = 1'b1;
          state_d  = SYNC_WAIT;
        end else if (timeout_q == TO_MAX) begin
          if (retry_q < RT_MAX) begin
            retry_d     = retry_q + 1'b1;
            state_d     = CFG_START;
            cfg_start_d = 1'b1;
          end else begin
            state_d   = FAULT;
            cfg_err_d = 1'b1;
          end
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      SYNC_WAIT: begin
        if (i_sof) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
          flush_d     = 1'b1;
          gauss_d     = sw_filt_q;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FL_MAX) begin
          state_d   = RUN;
          flush_d   = 1'b0;
          running_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (i_sof && change_pending) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
          flush_d     = 1'b1;
          gauss_d     = sw_filt_q;
          running_d   = 1'b0;
        end
`ifdef FRAME_SEQ_SOF_WDT_EN
        else if (!i_sof) begin
          if (wdt_q == WD_MAX) begin
            // Lost frames: restart the whole configuration with a fresh retry budget
            state_d     = CFG_START;
            cfg_start_d = 1'b1;
            config_d    = 1'b0;
            running_d   = 1'b0;
            retry_d     = '0;
          end else begin
            wdt_d = wdt_q + 1'b1;
          end
        end
`endif
      end
      FAULT: begin
        cfg_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      state_q     <= IDLE;
      sw_meta_q   <= 1'b0;
      sw_sync_q   <= 1'b0;
      sw_filt_q   <= 1'b0;
      stab_q      <= '0;
      cfg_done_q  <= 1'b0;
      timeout_q   <= '0;
      retry_q     <= '0;
      flush_cnt_q <= '0;
      cfg_start_q <= 1'b0;
      gauss_q     <= 1'b0;
      flush_q     <= 1'b0;
      running_q   <= 1'b0;
      config_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef FRAME_SEQ_SOF_WDT_EN
      wdt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      sw_filt_q   <= sw_filt_d;
      stab_q      <= stab_d;
      cfg_done_q  <= cfg_done_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
      flush_cnt_q <= flush_cnt_d;
      cfg_start_q <= cfg_start_d;
      gauss_q     <= gauss_d;
      flush_q     <= flush_d;
      running_q   <= running_d;
      config_q    <= config_d;
      cfg_err_q   <= cfg_err_d;
`ifdef FRAME_SEQ_SOF_WDT_EN
      wdt_q       <= wdt_d;
`endif
    end
  end

  assign o_cfg_start       = cfg_start_q;
  assign o_gaussian_enable = gauss_q;
  assign o_pipe_flush      = flush_q;
  assign o_running         = running_q;
  assign o_cfg_err         = cfg_err_q;
  assign o_status_leds     = {cfg_err_q, gauss_q, running_q, config_q};

endmodule
`default_nettype wire
